// File: rtl/cache_tag_nway_pkg.sv
// Shared types and geometry helpers for the N-way set-associative tag store.
package cache_tag_nway_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WB   = 3'd1,
    ST_RD   = 3'd2,
    ST_FILL = 3'd3,
    ST_INV  = 3'd4
  } state_e;

  function automatic int unsigned tag_width(input int unsigned addr_w,
                                            input int unsigned sets,
                                            input int unsigned offset_w);
    return addr_w - $clog2(sets) - offset_w;
  endfunction

  // Entry layout is {valid, dirty, tag}; positions depend on the tag width.
  function automatic int unsigned ent_valid_bit(input int unsigned tag_w);
    return tag_w + 1;
  endfunction

  function automatic int unsigned ent_dirty_bit(input int unsigned tag_w);
    return tag_w;
  endfunction

endpackage

// File: rtl/cache_tag_nway_plru_tree.sv
// Combinational tree pseudo-LRU: updates the path away from an accessed way
// and walks the tree bits (each pointing at the LRU side) to a victim way.
module cache_tag_nway_plru_tree
  import cache_tag_nway_pkg::*;
#(
  parameter int unsigned WAYS = 4
) (
  input  logic [WAYS-2:0]         tree_i,
  input  logic [$clog2(WAYS)-1:0] way_i,
  output logic [WAYS-2:0]         tree_o,
  output logic [$clog2(WAYS)-1:0] victim_o
);

  localparam int unsigned LVLS = $clog2(WAYS);

  // Heap layout: node n has children 2n+1 (lower ways) and 2n+2 (upper ways).
  always_comb begin
    int unsigned node;
    tree_o = tree_i;
    node   = 0;
    for (int unsigned l = 0; l < LVLS; l++) begin
      tree_o[node] = ~way_i[LVLS-1-l];
      node = 2 * node + 1 + 32'(way_i[LVLS-1-l]);
    end
  end

  always_comb begin
    int unsigned node;
    victim_o = '0;
    node     = 0;
    for (int unsigned l = 0; l < LVLS; l++) begin
      victim_o[LVLS-1-l] = tree_i[node];
      node = 2 * node + 1 + 32'(tree_i[node]);
    end
  end

endmodule

// File: rtl/cache_tag_nway.sv
// N-way set-associative tag store with tree PLRU, dirty tracking and a
// miss/write-back/refill/invalidate FSM. Optional counters: CACHE_TAG_PERF_EN.
module cache_tag_nway
  import cache_tag_nway_pkg::*;
#(
  parameter int unsigned WAYS     = 4,
  parameter int unsigned SETS     = 64,
  parameter int unsigned OFFSET_W = 6,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cached,
  input  logic              sram_en,
  input  logic              sram_we,
  input  logic [ADDR_W-1:0] sram_addr,
  output logic              stallreq,
  output logic [WAYS-1:0]   hit,
  output logic [WAYS-1:0]   fill_way,
  output logic              refresh,
  output logic              miss,
  output logic              rd_req,
  output logic [ADDR_W-1:0] axi_raddr,
  input  logic              rd_done,
  output logic              wb_req,
  output logic [ADDR_W-1:0] axi_waddr,
  input  logic              wb_done,
  input  logic              inv_all,
  output logic              inv_busy
`ifdef CACHE_TAG_PERF_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int unsigned INDEX_W = $clog2(SETS);
  localparam int unsigned TAG_W   = tag_width(ADDR_W, SETS, OFFSET_W);
  localparam int unsigned WAY_W   = $clog2(WAYS);
  localparam int unsigned LINE_W  = ADDR_W - OFFSET_W;
  localparam int unsigned ENT_W   = TAG_W + 2;
  localparam int unsigned VB      = ent_valid_bit(TAG_W);
  localparam int unsigned DB      = ent_dirty_bit(TAG_W);

  logic [ENT_W-1:0]   ent_q  [SETS][WAYS];
  logic [WAYS-2:0]    plru_q [SETS];

  state_e             state_q, state_d;
  logic [LINE_W-1:0]  laddr_q, laddr_d;
  logic               lwe_q, lwe_d;
  logic [WAY_W-1:0]   victim_q, victim_d;
  logic               wb_req_q, wb_req_d;
  logic               rd_req_q, rd_req_d;
  logic               refresh_q, refresh_d;
  logic [WAYS-1:0]    fill_way_q, fill_way_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic               inv_busy_q, inv_busy_d;
  logic [INDEX_W-1:0] sweep_q, sweep_d;

  logic [TAG_W-1:0]   acc_tag, line_tag;
  logic [INDEX_W-1:0] acc_idx, line_idx;
  logic [WAY_W-1:0]   hit_way, plru_victim, victim_sel, unused_fill_victim;
  logic [WAYS-2:0]    hit_tree, fill_tree;
  logic [ENT_W-1:0]   vent;

  assign acc_tag  = sram_addr[ADDR_W-1 -: TAG_W];
  assign acc_idx  = sram_addr[OFFSET_W +: INDEX_W];
  assign line_tag = laddr_q[LINE_W-1 -: TAG_W];
  assign line_idx = laddr_q[INDEX_W-1:0];

  always_comb begin
    hit     = '0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!flush && cached && sram_en && ent_q[acc_idx][w][VB] &&
          (ent_q[acc_idx][w][TAG_W-1:0] == acc_tag)) begin
        hit[w]  = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign miss     = (state_q == ST_IDLE) && !flush && cached && sram_en && !(|hit);
  assign stallreq = miss || (state_q != ST_IDLE);

  // The access-set instance serves both the hit update and the PLRU victim.
  cache_tag_nway_plru_tree #(.WAYS(WAYS)) u_plru_hit (
    .tree_i   (plru_q[acc_idx]),
    .way_i    (hit_way),
    .tree_o   (hit_tree),
    .victim_o (plru_victim)
  );

  cache_tag_nway_plru_tree #(.WAYS(WAYS)) u_plru_fill (
    .tree_i   (plru_q[line_idx]),
    .way_i    (victim_q),
    .tree_o   (fill_tree),
    .victim_o (unused_fill_victim)
  );

  always_comb begin
    logic found;
    found      = 1'b0;
    victim_sel = plru_victim;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && !ent_q[acc_idx][w][VB]) begin
        found      = 1'b1;
        victim_sel = WAY_W'(w);
      end
    end
  end

  assign vent = ent_q[acc_idx][victim_sel];

  always_comb begin
    state_d    = state_q;
    laddr_d    = laddr_q;
    lwe_d      = lwe_q;
    victim_d   = victim_q;
    wb_req_d   = wb_req_q;
    rd_req_d   = rd_req_q;
    refresh_d  = 1'b0;
    fill_way_d = fill_way_q;
    waddr_d    = waddr_q;
    inv_busy_d = inv_busy_q;
    sweep_d    = sweep_q;
    unique case (state_q)
      ST_IDLE: begin
        if (inv_all) begin
          state_d    = ST_INV;
          inv_busy_d = 1'b1;
          sweep_d    = '0;
        end else if (miss) begin
          laddr_d  = sram_addr[ADDR_W-1:OFFSET_W];
          lwe_d    = sram_we;
          victim_d = victim_sel;
          if (vent[VB] && vent[DB]) begin
            state_d  = ST_WB;
            wb_req_d = 1'b1;
            waddr_d  = {vent[TAG_W-1:0], acc_idx, {OFFSET_W{1'b0}}};
          end else begin
            state_d  = ST_RD;
            rd_req_d = 1'b1;
          end
        end
      end
      ST_WB: begin
        if (wb_done) begin
          state_d  = ST_RD;
          wb_req_d = 1'b0;
          rd_req_d = 1'b1;
        end
      end
      ST_RD: begin
        if (rd_done) begin
          state_d              = ST_FILL;
          rd_req_d             = 1'b0;
          refresh_d            = 1'b1;
          fill_way_d           = '0;
          fill_way_d[victim_q] = 1'b1;
        end
      end
      ST_FILL: begin
        state_d    = ST_IDLE;
        fill_way_d = '0;
      end
      ST_INV: begin
        if (sweep_q == INDEX_W'(SETS - 1)) begin
          state_d    = ST_IDLE;
          inv_busy_d = 1'b0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      laddr_q    <= '0;
      lwe_q      <= 1'b0;
      victim_q   <= '0;
      wb_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      refresh_q  <= 1'b0;
      fill_way_q <= '0;
      waddr_q    <= '0;
      inv_busy_q <= 1'b0;
      sweep_q    <= '0;
    end else begin
      state_q    <= state_d;
      laddr_q    <= laddr_d;
      lwe_q      <= lwe_d;
      victim_q   <= victim_d;
      wb_req_q   <= wb_req_d;
      rd_req_q   <= rd_req_d;
      refresh_q  <= refresh_d;
      fill_way_q <= fill_way_d;
      waddr_q    <= waddr_d;
      inv_busy_q <= inv_busy_d;
      sweep_q    <= sweep_d;
    end
  end

  // Later writes take priority: the refill install and the sweep override a hit update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) ent_q[s][w] <= '0;
      end
    end else begin
      if (|hit) begin
        plru_q[acc_idx] <= hit_tree;
        if (sram_we) ent_q[acc_idx][hit_way][DB] <= 1'b1;
      end
      if (state_q == ST_FILL) begin
        ent_q[line_idx][victim_q] <= {1'b1, lwe_q, line_tag};
        plru_q[line_idx]          <= fill_tree;
      end
      if (state_q == ST_INV) begin
        plru_q[sweep_q] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          ent_q[sweep_q][w][VB] <= 1'b0;
          ent_q[sweep_q][w][DB] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    if (state_q == ST_RD)                            axi_raddr = {laddr_q, {OFFSET_W{1'b0}}};
    else if (state_q == ST_IDLE && sram_en && !cached) axi_raddr = sram_addr;
    else                                             axi_raddr = '0;
  end

  assign wb_req    = wb_req_q;
  assign rd_req    = rd_req_q;
  assign refresh   = refresh_q;
  assign fill_way  = fill_way_q;
  assign axi_waddr = waddr_q;
  assign inv_busy  = inv_busy_q;

`ifdef CACHE_TAG_PERF_EN
  logic        stall_prev_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_prev_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      stall_prev_q <= stallreq;
      if (|hit && !stall_prev_q) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == ST_IDLE && (state_d == ST_WB || state_d == ST_RD))
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_tag_nway.sv
// Self-checking bench for cache_tag_nway (WAYS=4, SETS=64, OFFSET_W=6):
// directed vector table, hand sequences, then random traffic against a model.
module tb_cache_tag_nway;

  logic        clk = 1'b0;
  logic        rst, flush, cached, sram_en, sram_we;
  logic [31:0] sram_addr;
  logic        stallreq;
  logic [3:0]  hit, fill_way;
  logic        refresh, miss, rd_req;
  logic [31:0] axi_raddr, axi_waddr;
  logic        rd_done, wb_req, wb_done, inv_all, inv_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_tag_nway #(.WAYS(4), .SETS(64), .OFFSET_W(6), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cached(cached), .sram_en(sram_en),
    .sram_we(sram_we), .sram_addr(sram_addr), .stallreq(stallreq), .hit(hit),
    .fill_way(fill_way), .refresh(refresh), .miss(miss), .rd_req(rd_req),
    .axi_raddr(axi_raddr), .rd_done(rd_done), .wb_req(wb_req),
    .axi_waddr(axi_waddr), .wb_done(wb_done), .inv_all(inv_all),
    .inv_busy(inv_busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we, cached, flush;
    logic [3:0]  exp_hit;
    logic        exp_miss, exp_wb;
    logic [31:0] exp_waddr;
    logic [3:0]  exp_fill;
  } vec_t;

  // Reference model: per-set lines plus tree bits kept as [level][position].
  bit          m_valid [64][4];
  bit          m_dirty [64][4];
  logic [19:0] m_tag   [64][4];
  bit          m_pl    [64][2][2];

  task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, what, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic we, input logic c, input logic f,
                              input logic [3:0] h, input logic m, input logic wb,
                              input logic [31:0] wa, input logic [3:0] fw);
    vec_t v;
    v.addr = a; v.we = we; v.cached = c; v.flush = f; v.exp_hit = h;
    v.exp_miss = m; v.exp_wb = wb; v.exp_waddr = wa; v.exp_fill = fw;
    return v;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < 64; s++) begin
      for (int w = 0; w < 4; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = '0; end
      m_pl[s][0][0] = 0; m_pl[s][0][1] = 0; m_pl[s][1][0] = 0; m_pl[s][1][1] = 0;
    end
  endfunction

  function automatic void m_touch(input int s, input int w);
    for (int l = 0; l < 2; l++) m_pl[s][l][w >> (2 - l)] = !(((w >> (1 - l)) & 1) != 0);
  endfunction

  function automatic int m_victim(input int s);
    int pos;
    for (int w = 0; w < 4; w++) if (!m_valid[s][w]) return w;
    pos = 0;
    for (int l = 0; l < 2; l++) pos = pos * 2 + int'(m_pl[s][l][pos]);
    return pos;
  endfunction

  function automatic int m_lookup(input int s, input logic [19:0] t);
    for (int w = 0; w < 4; w++) if (m_valid[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  // Called just after a negedge; returns just after a negedge with the access dropped.
  task automatic apply(input vec_t v, input string nm);
    sram_en = 1'b1; sram_addr = v.addr; sram_we = v.we; cached = v.cached; flush = v.flush;
    #1;
    chk(nm, "hit", 32'(hit), 32'(v.exp_hit));
    chk(nm, "miss", 32'(miss), 32'(v.exp_miss));
    chk(nm, "stallreq", 32'(stallreq), 32'(v.exp_miss));
    if (!v.exp_miss) begin
      if (!v.cached) chk(nm, "axi_raddr_uncached", axi_raddr, v.addr);
      @(negedge clk);
      sram_en = 1'b0; flush = 1'b0; cached = 1'b1; sram_we = 1'b0;
      chk(nm, "idle_no_req", {30'd0, wb_req, rd_req}, 32'd0);
    end else begin
      @(negedge clk);
      chk(nm, "wb_req", 32'(wb_req), 32'(v.exp_wb));
      if (v.exp_wb) begin
        chk(nm, "axi_waddr", axi_waddr, v.exp_waddr);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        chk(nm, "rd_before_wb_done", 32'(rd_req), 32'd0);
        wb_done = 1'b1;
        @(negedge clk);
        wb_done = 1'b0;
        chk(nm, "wb_req_drop", 32'(wb_req), 32'd0);
      end
      chk(nm, "rd_req", 32'(rd_req), 32'd1);
      chk(nm, "axi_raddr", axi_raddr, {v.addr[31:6], 6'b0});
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rd_done = 1'b1;
      @(negedge clk);
      rd_done = 1'b0;
      chk(nm, "refresh", 32'(refresh), 32'd1);
      chk(nm, "fill_way", 32'(fill_way), 32'(v.exp_fill));
      chk(nm, "rd_req_drop", 32'(rd_req), 32'd0);
      @(negedge clk);
      #1;
      chk(nm, "refresh_pulse", 32'(refresh), 32'd0);
      chk(nm, "rehit", 32'(hit), 32'(v.exp_fill));
      chk(nm, "rehit_stall", 32'(stallreq), 32'd0);
      @(negedge clk);
      sram_en = 1'b0; flush = 1'b0; cached = 1'b1; sram_we = 1'b0;
    end
  endtask

  task automatic inv_sweep(input string nm);
    int n;
    inv_all = 1'b1;
    @(negedge clk);
    inv_all = 1'b0;
    chk(nm, "no_bus_req", {30'd0, wb_req, rd_req}, 32'd0);
    n = 0;
    while (inv_busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(nm, "busy_cycles", 32'(n), 32'd64);
  endtask

  vec_t tbl [17];

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   s, w, vw;
    logic [19:0] t;

    tbl[0]  = mk(32'h1000_0048, 0, 1, 0, 4'b0000, 1, 0, 32'h0, 4'b0001);
    tbl[1]  = mk(32'h1000_0040, 0, 1, 0, 4'b0001, 0, 0, 32'h0, 4'b0000);
    tbl[2]  = mk(32'h2000_0040, 0, 1, 0, 4'b0000, 1, 0, 32'h0, 4'b0010);
    tbl[3]  = mk(32'h3000_0040, 0, 1, 0, 4'b0000, 1, 0, 32'h0, 4'b0100);
    tbl[4]  = mk(32'h4000_0040, 0, 1, 0, 4'b0000, 1, 0, 32'h0, 4'b1000);
    tbl[5]  = mk(32'h1000_0040, 0, 1, 0, 4'b0001, 0, 0, 32'h0, 4'b0000);
    tbl[6]  = mk(32'h5000_0040, 0, 1, 0, 4'b0000, 1, 0, 32'h0, 4'b0100);
    tbl[7]  = mk(32'h5000_0044, 1, 1, 0, 4'b0100, 0, 0, 32'h0, 4'b0000);
    tbl[8]  = mk(32'h4000_0040, 0, 1, 0, 4'b1000, 0, 0, 32'h0, 4'b0000);
    tbl[9]  = mk(32'h1000_0040, 0, 1, 0, 4'b0001, 0, 0, 32'h0, 4'b0000);
    tbl[10] = mk(32'h6000_0040, 0, 1, 0, 4'b0000, 1, 1, 32'h5000_0040, 4'b0100);
    tbl[11] = mk(32'h7000_0040, 0, 1, 0, 4'b0000, 1, 0, 32'h0, 4'b0010);
    tbl[12] = mk(32'h8000_0040, 0, 1, 1, 4'b0000, 0, 0, 32'h0, 4'b0000);
    tbl[13] = mk(32'h1000_0040, 0, 1, 1, 4'b0000, 0, 0, 32'h0, 4'b0000);
    tbl[14] = mk(32'h1FC0_0004, 0, 0, 0, 4'b0000, 0, 0, 32'h0, 4'b0000);
    tbl[15] = mk(32'h2000_0084, 1, 1, 0, 4'b0000, 1, 0, 32'h0, 4'b0001);
    tbl[16] = mk(32'h2000_0080, 0, 1, 0, 4'b0001, 0, 0, 32'h0, 4'b0000);

    rst = 1'b1; flush = 1'b0; cached = 1'b1; sram_en = 1'b0; sram_we = 1'b0;
    sram_addr = '0; rd_done = 1'b0; wb_done = 1'b0; inv_all = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset", "outputs", {20'd0, hit, fill_way, stallreq, refresh, rd_req, wb_req}, 32'd0);
    chk("reset", "inv_busy", 32'(inv_busy), 32'd0);
    chk("reset", "axi_raddr", axi_raddr, 32'd0);

    for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Flush raised during RD: the refill completes and the line installs.
    sram_en = 1'b1; cached = 1'b1; sram_we = 1'b0; sram_addr = 32'h9000_0040;
    #1 chk("flush_rd", "miss", 32'(miss), 32'd1);
    @(negedge clk);
    chk("flush_rd", "rd_req", 32'(rd_req), 32'd1);
    flush = 1'b1;
    repeat (2) @(negedge clk);
    chk("flush_rd", "rd_req_held", 32'(rd_req), 32'd1);
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    chk("flush_rd", "refresh", 32'(refresh), 32'd1);
    chk("flush_rd", "fill_way", 32'(fill_way), 32'b1000);
    @(negedge clk);
    #1 chk("flush_rd", "hit_flushed", {27'd0, hit, miss}, 32'd0);
    flush = 1'b0;
    #1 chk("flush_rd", "hit_after", 32'(hit), 32'b1000);
    @(negedge clk);
    sram_en = 1'b0;

    // Invalidate everything, then previously resident lines miss (invalid-first fill).
    inv_sweep("inv");
    apply(mk(32'h1000_0040, 0, 1, 0, 4'b0000, 1, 0, 32'h0, 4'b0001), "inv_a");
    apply(mk(32'h6000_0040, 0, 1, 0, 4'b0000, 1, 0, 32'h0, 4'b0010), "inv_f");

    // inv_all together with a miss: the sweep runs first, then the access refills.
    sram_en = 1'b1; cached = 1'b1; sram_we = 1'b0; sram_addr = 32'h2000_0040;
    #1 chk("inv_miss", "stallreq", 32'(stallreq), 32'd1);
    inv_sweep("inv_miss");
    apply(mk(32'h2000_0040, 0, 1, 0, 4'b0000, 1, 0, 32'h0, 4'b0001), "inv_miss_acc");

    // Reset in the middle of a refill drops the request immediately.
    sram_en = 1'b1; cached = 1'b1; sram_addr = 32'hA000_0140;
    @(negedge clk);
    chk("midrst", "rd_req_before", 32'(rd_req), 32'd1);
    rst = 1'b1; sram_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst", "outputs", {28'd0, rd_req, wb_req, stallreq, refresh}, 32'd0);
    m_clear();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        inv_sweep($sformatf("rnd_inv%0d", i));
        m_clear();
      end else begin
        s = $urandom_range(0, 3);
        t = 20'($urandom_range(1, 6));
        v.addr = {t, 6'(s), 6'($urandom_range(0, 63))};
        v.we = 1'($urandom_range(0, 1));
        v.cached = ($urandom_range(0, 9) != 0);
        v.flush = ($urandom_range(0, 9) == 0);
        v.exp_hit = '0; v.exp_miss = 0; v.exp_wb = 0; v.exp_waddr = '0; v.exp_fill = '0;
        w = m_lookup(s, t);
        vw = m_victim(s);
        if (v.cached && !v.flush) begin
          if (w >= 0) v.exp_hit = 4'(1 << w);
          else begin
            v.exp_miss = 1;
            v.exp_wb = m_valid[s][vw] && m_dirty[s][vw];
            v.exp_waddr = {m_tag[s][vw], 6'(s), 6'b0};
            v.exp_fill = 4'(1 << vw);
          end
        end
        apply(v, $sformatf("rnd%0d", i));
        if (v.cached && !v.flush) begin
          if (w >= 0) begin
            m_touch(s, w);
            if (v.we) m_dirty[s][w] = 1;
          end else begin
            m_valid[s][vw] = 1; m_dirty[s][vw] = v.we; m_tag[s][vw] = t;
            m_touch(s, vw);
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_tag_nway.md
Name: cache_tag_nway

Overview:
- Parametrised N-way set-associative tag store with tree pseudo-LRU replacement, per-line valid and dirty bits, and an owned miss/write-back/refill state machine.
- Sits between the pipeline memory port and the AXI bridge. Drives way-select and refill strobes to the cache data array.
- Successor to the fixed 2-way tag block. Adds: generalised geometry, true dirty tracking (write-back only for dirty lines), invalid-first victim choice, and whole-cache invalidate.

Parameters:
- WAYS, 4, associativity; power of two, 2..8.
- SETS, 64, number of sets; power of two.
- OFFSET_W, 6, byte-offset bits per line (64-byte line).
- ADDR_W, 32, address width; TAG_W = ADDR_W - log2(SETS) - OFFSET_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush; suppresses new hit/miss this cycle.
- cached  in  1  access is cacheable.
- sram_en  in  1  access valid.
- sram_we  in  1  access is a store.
- sram_addr  in  ADDR_W  access address.
- stallreq  out  1  pipeline stall request.
- hit  out  WAYS  one-hot hitting way (combinational).
- fill_way  out  WAYS  one-hot way being refilled; valid while refresh=1.
- refresh  out  1  one-cycle pulse: data array commits refill line.
- miss  out  1  miss detected in IDLE this cycle.
- rd_req  out  1  refill read request, level.
- axi_raddr  out  ADDR_W  refill address.
- rd_done  in  1  refill complete pulse.
- wb_req  out  1  write-back request, level.
- axi_waddr  out  ADDR_W  victim line address.
- wb_done  in  1  write-back complete pulse.
- inv_all  in  1  invalidate-all request pulse.
- inv_busy  out  1  invalidate sweep in progress.

Behaviour:
- Address split: {tag, index, offset}.
- Entry = {valid, dirty, tag}. PLRU state = WAYS-1 tree bits per set; each bit points toward the LRU subtree.
- Reset: all valid/dirty/PLRU bits cleared; FSM to IDLE; all outputs 0.
- Hit: hit[w] = ~flush & cached & sram_en & valid[w] & tag match. Same-cycle, no latency. At most one bit set.
- On a hit, at the next edge:
  - PLRU path updated to point away from the hit way.
  - If sram_we, dirty[w] is set.
- miss = IDLE & ~flush & cached & sram_en & ~|hit.
- stallreq = miss | (state != IDLE).
- FSM states: IDLE, WB, RD, FILL, INV.
- IDLE on miss:
  - Latch address.
  - Victim = lowest-index invalid way; otherwise the PLRU leaf.
  - If the victim is valid & dirty, go to WB; else go to RD.
- WB:
  - wb_req = 1.
  - axi_waddr = {victim tag, index, OFFSET_W'b0}.
  - Transition to RD on wb_done.
- RD:
  - rd_req = 1.
  - axi_raddr = {latched addr[ADDR_W-1:OFFSET_W], 0}.
  - Transition to FILL on rd_done.
- FILL (one cycle):
  - refresh = 1; fill_way = victim.
  - Entry written {1, latched sram_we, tag}.
  - PLRU updated away from the victim.
  - Transition to IDLE.
- Flush during WB/RD/FILL does not abort: the bus transaction completes and the line is installed.
- Uncached access: hit = 0, miss = 0, stallreq = 0. axi_raddr = sram_addr unaligned, for the uncached path.
- inv_all:
  - Sampled in IDLE only; wins over a simultaneous miss. The access re-evaluates after the sweep.
  - INV sweeps one set per cycle from 0 to SETS-1, clearing valid, dirty and PLRU. No write-back is performed; callers clean first.
  - inv_busy = 1 for exactly SETS cycles, then the FSM returns to IDLE.
  - inv_all outside IDLE is ignored.
- rd_done/wb_done outside their states are ignored.
- Reset mid-operation returns to IDLE immediately. Request outputs drop the same edge.

Optional Feature:
- Macro CACHE_TAG_PERF_EN.
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments on any cycle with |hit & ~stallreq_prev.
  - miss_cnt increments on each IDLE->WB/RD transition.
  - Both wrap at 2^32 and are cleared by rst.
- Undefined: ports and counters absent. Behaviour otherwise identical.

Decomposition:
- Shared package/defines: TAG_W/INDEX_W derivation, FSM state encodings, entry field positions.
- One natural sub-module: plru_tree (WAYS param). Per-set tree bits in, accessed way in, updated bits and victim way out. Purely combinational, instantiated twice: hit update and fill/victim.

Test Plan:
All cases use WAYS=4, SETS=64, OFFSET_W=6.
- Cold miss:
  - Stimulus: after reset, cached load 0x1000_0048.
  - Required: miss=1, stallreq=1, no wb_req; rd_req with axi_raddr=0x1000_0040.
  - Then: rd_done gives refresh pulse with fill_way=0001; the next access to 0x1000_0040 gives hit=0001, stallreq=0.
- PLRU:
  - Stimulus: fill ways 0,1,2,3 of set 1 with tags A..D, hit tag A, then miss tag E.
  - Required: fill_way=0100 (way2); wb_req=0.
- Dirty write-back:
  - Stimulus: store hit to way2, then evict way2.
  - Required: wb_req with axi_waddr = old line address; RD begins only after wb_done.
  - Contrast: a clean victim never raises wb_req.
- Flush:
  - Stimulus: flush=1 with a missing cached access.
  - Required: miss=0, hit=0, state stays IDLE.
  - Stimulus: flush during RD. Required: refill still completes and the line subsequently hits.
- Invalidate:
  - Stimulus: inv_all pulse.
  - Required: inv_busy high for 64 cycles; all prior lines then miss. inv_all raised together with a miss takes INV first.
- Uncached:
  - Stimulus: cached=0, load 0x1FC0_0004.
  - Required: hit=0, miss=0, stallreq=0, axi_raddr=0x1FC0_0004.
